systolic_array_ctrl: RTL and testbench

- Sequencer that owns one systolicArray instance (N x N int8 PEs, 32-bit accumulators).
- Buffers one N x N A tile (by row) and one N x N B tile (by column) written by the host.
- On start, it clears the array accumulators and streams diagonally skewed, zero-padded operands into the array's first column and first row, with i_doProcess gated.
- Signals done when every o_c[i][j] holds the full dot product, and holds it until acknowledged.

---
 rtl/systolic_array_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_systolic_array_ctrl.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_array_ctrl.sv
// systolic_array_ctrl
//   Sequencer for one N x N systolicArray. The host fills an A tile by rows and
//   a B tile by columns. On start, the array accumulators are cleared for one
//   cycle. Then 3N-2 steps of diagonally skewed, zero-padded operands are
//   streamed into row inputs and column inputs while i_doProcess is high.
//   Completion is signalled on o_done until the host acknowledges it.
//
//   Optional: define SA_CTRL_PERF_CNT_EN to add o_jobCount / o_busyCycles.
//
// Ports
//   i_clk, i_arst         clock, synchronous active-high reset
//   i_loadValid/o_loadReady/i_loadSel/i_loadIdx/i_loadData
//                         tile load (sel 0: A row idx, sel 1: B column idx)
//   i_start, i_ack        job start (IDLE only), result acknowledge (DONE only)
//   o_busy, o_done        status
//   o_arrayClr            one-cycle accumulator clear for the array
//   o_doProcess           array advance enable
//   o_rowFeed, o_colFeed  lane i -> array row input i / column input i
//   o_jobCount, o_busyCycles  (SA_CTRL_PERF_CNT_EN only)
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | accepts loads and start; buffers retained
// CLEAR  | one cycle of o_arrayClr, feeds zero
// FEED   | step t = 0..3N-3 presented on the feeds with o_doProcess=1
// DONE   | results valid in the array; wait for i_ack

module systolic_array_ctrl #(
  parameter int N  = 8,
  parameter int DW = 8
) (
  input  logic                 i_clk,
  input  logic                 i_arst,
  input  logic                 i_loadValid,
  output logic                 o_loadReady,
  input  logic                 i_loadSel,
  input  logic [$clog2(N)-1:0] i_loadIdx,
  input  logic [N*DW-1:0]      i_loadData,
  input  logic                 i_start,
  input  logic                 i_ack,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_arrayClr,
  output logic                 o_doProcess,
  output logic [N*DW-1:0]      o_rowFeed,
  output logic [N*DW-1:0]      o_colFeed
`ifdef SA_CTRL_PERF_CNT_EN
  ,
  output logic [31:0]          o_jobCount,
  output logic [31:0]          o_busyCycles
`endif
);

  localparam int TW = $clog2(3*N);
  localparam logic [TW-1:0] T_LAST = TW'(3*N-3);

  typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_FEED, S_DONE} state_t;

  state_t            r_state;
  logic [TW-1:0]     r_t;
  // Both tiles stored row-major: element [r][c] lives at (r*N + c)*DW.
  logic [N*N*DW-1:0] r_a;
  logic [N*N*DW-1:0] r_b;
  logic              r_loadReady;
  logic              r_busy;
  logic              r_done;
  logic              r_arrayClr;
  logic              r_doProcess;
  logic [N*DW-1:0]   r_rowFeed;
  logic [N*DW-1:0]   r_colFeed;

  int                w_step;
  int                w_idx;
  logic              w_idxOk;
  logic [N*DW-1:0]   w_rowNext;
  logic [N*DW-1:0]   w_colNext;

  assign w_idx   = int'(i_loadIdx);
  assign w_idxOk = (w_idx < N);

  // Step whose operands get registered at the coming edge: 0 when leaving
  // CLEAR, t+1 while in FEED.
  assign w_step = (r_state == S_FEED) ? int'(r_t) + 1 : 0;

  // Diagonal skew: lane i carries element k = step - i, zero outside 0..N-1.
  always_comb begin
    w_rowNext = '0;
    w_colNext = '0;
    for (int i = 0; i < N; i++) begin
      if (w_step >= i && (w_step - i) < N) begin
        w_rowNext[i*DW +: DW] = r_a[(i*N + w_step - i)*DW +: DW];
        w_colNext[i*DW +: DW] = r_b[((w_step - i)*N + i)*DW +: DW];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_arst) begin
      r_state     <= S_IDLE;
      r_t         <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_loadReady <= 1'b1;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_arrayClr  <= 1'b0;
      r_doProcess <= 1'b0;
      r_rowFeed   <= '0;
      r_colFeed   <= '0;
    end else begin
      r_arrayClr  <= 1'b0;
      r_doProcess <= 1'b0;
      r_rowFeed   <= '0;
      r_colFeed   <= '0;
      case (r_state)
        S_IDLE: begin
          // A load coinciding with start lands before CLEAR, so the job sees it.
          if (i_loadValid && w_idxOk) begin
            for (int k = 0; k < N; k++) begin
              if (i_loadSel) r_b[(k*N + w_idx)*DW +: DW] <= i_loadData[k*DW +: DW];
              else           r_a[(w_idx*N + k)*DW +: DW] <= i_loadData[k*DW +: DW];
            end
          end
          if (i_start) begin
            r_state     <= S_CLEAR;
            r_loadReady <= 1'b0;
            r_busy      <= 1'b1;
            r_arrayClr  <= 1'b1;
          end
        end
        S_CLEAR: begin
          r_state     <= S_FEED;
          r_t         <= '0;
          r_doProcess <= 1'b1;
          r_rowFeed   <= w_rowNext;
          r_colFeed   <= w_colNext;
        end
        S_FEED: begin
          if (r_t == T_LAST) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            // Only advanced below T_LAST, so t never wraps inside a job.
            r_t         <= r_t + TW'(1);
            r_doProcess <= 1'b1;
            r_rowFeed   <= w_rowNext;
            r_colFeed   <= w_colNext;
          end
        end
        S_DONE: begin
          // Ack has priority; a start seen here is dropped.
          if (i_ack) begin
            r_state     <= S_IDLE;
            r_done      <= 1'b0;
            r_loadReady <= 1'b1;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_busy      <= 1'b0;
          r_done      <= 1'b0;
          r_loadReady <= 1'b1;
        end
      endcase
    end
  end

  assign o_loadReady = r_loadReady;
  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_arrayClr  = r_arrayClr;
  assign o_doProcess = r_doProcess;
  assign o_rowFeed   = r_rowFeed;
  assign o_colFeed   = r_colFeed;

`ifdef SA_CTRL_PERF_CNT_EN
  logic [31:0] r_jobCount;
  logic [31:0] r_busyCycles;

  always_ff @(posedge i_clk) begin
    if (i_arst) begin
      r_jobCount   <= '0;
      r_busyCycles <= '0;
    end else begin
      if (r_state == S_DONE && i_ack) r_jobCount <= r_jobCount + 32'd1;
      if (r_busy)                      r_busyCycles <= r_busyCycles + 32'd1;
    end
  end

  assign o_jobCount   = r_jobCount;
  assign o_busyCycles = r_busyCycles;
`endif

endmodule

// File: tb/tb_systolic_array_ctrl.sv
// Bench for systolic_array_ctrl: an N=2 and an N=8 instance, each driving a
// small behavioural systolic array so that results can be compared against
// hand-computed matrix products.

module tb_systolic_array_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic arst;

  // N = 2 instance
  logic        ld2_v, ld2_sel, ld2_idx, st2, ak2;
  logic [15:0] ld2_data;
  logic        ready2, busy2, done2, clr2, dp2;
  logic [15:0] row2, col2;

  // N = 8 instance
  logic        ld8_v, ld8_sel, st8, ak8;
  logic [2:0]  ld8_idx;
  logic [63:0] ld8_data;
  logic        ready8, busy8, done8, clr8, dp8;
  logic [63:0] row8, col8;

`ifdef SA_CTRL_PERF_CNT_EN
  logic [31:0] jobcnt2, busycyc2, jobcnt8, busycyc8;
`endif

  systolic_array_ctrl #(.N(2), .DW(8)) u_dut2 (
    .i_clk(clk), .i_arst(arst),
    .i_loadValid(ld2_v), .o_loadReady(ready2), .i_loadSel(ld2_sel),
    .i_loadIdx(ld2_idx), .i_loadData(ld2_data),
    .i_start(st2), .i_ack(ak2),
    .o_busy(busy2), .o_done(done2), .o_arrayClr(clr2), .o_doProcess(dp2),
    .o_rowFeed(row2), .o_colFeed(col2)
`ifdef SA_CTRL_PERF_CNT_EN
    , .o_jobCount(jobcnt2), .o_busyCycles(busycyc2)
`endif
  );

  systolic_array_ctrl #(.N(8), .DW(8)) u_dut8 (
    .i_clk(clk), .i_arst(arst),
    .i_loadValid(ld8_v), .o_loadReady(ready8), .i_loadSel(ld8_sel),
    .i_loadIdx(ld8_idx), .i_loadData(ld8_data),
    .i_start(st8), .i_ack(ak8),
    .o_busy(busy8), .o_done(done8), .o_arrayClr(clr8), .o_doProcess(dp8),
    .o_rowFeed(row8), .o_colFeed(col8)
`ifdef SA_CTRL_PERF_CNT_EN
    , .o_jobCount(jobcnt8), .o_busyCycles(busycyc8)
`endif
  );

  // Behavioural systolic arrays: a moves right, b moves down, each PE
  // accumulates a*b whenever doProcess is high; arrayClr zeroes everything.
  logic        clr_w [2];
  logic        dp_w  [2];
  logic [63:0] row_w [2];
  logic [63:0] col_w [2];
  assign clr_w[0] = clr2;  assign clr_w[1] = clr8;
  assign dp_w[0]  = dp2;   assign dp_w[1]  = dp8;
  assign row_w[0] = {48'b0, row2};  assign row_w[1] = row8;
  assign col_w[0] = {48'b0, col2};  assign col_w[1] = col8;

  for (genvar g = 0; g < 2; g++) begin : g_arr
    localparam int M = (g == 0) ? 2 : 8;
    logic signed [7:0]  a_q  [M][M];
    logic signed [7:0]  b_q  [M][M];
    logic signed [7:0]  a_in [M][M];
    logic signed [7:0]  b_in [M][M];
    logic signed [31:0] c    [M][M];

    always_comb begin
      for (int i = 0; i < M; i++) begin
        for (int j = 0; j < M; j++) begin
          a_in[i][j] = (j == 0) ? row_w[g][i*8 +: 8] : a_q[i][(j == 0) ? 0 : j-1];
          b_in[i][j] = (i == 0) ? col_w[g][j*8 +: 8] : b_q[(i == 0) ? 0 : i-1][j];
        end
      end
    end

    always_ff @(posedge clk) begin
      for (int i = 0; i < M; i++) begin
        for (int j = 0; j < M; j++) begin
          if (clr_w[g]) begin
            a_q[i][j] <= '0;
            b_q[i][j] <= '0;
            c[i][j]   <= '0;
          end else if (dp_w[g]) begin
            a_q[i][j] <= a_in[i][j];
            b_q[i][j] <= b_in[i][j];
            c[i][j]   <= c[i][j] + 32'(a_in[i][j]) * 32'(b_in[i][j]);
          end
        end
      end
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic signed [63:0] act,
                     input logic signed [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Caller raises start (and any load) first; latency counts cycles until done.
  task automatic wait_done(input int which, input int exp_lat, input string nm);
    int   lat;
    logic seen;
    lat  = 0;
    seen = 1'b0;
    for (int k = 1; k <= 100 && !seen; k++) begin
      tick();
      st2 = 1'b0; ld2_v = 1'b0; st8 = 1'b0; ld8_v = 1'b0;
      if ((which == 0) ? done2 : done8) begin
        lat  = k;
        seen = 1'b1;
      end
    end
    chk({nm, " done latency"}, lat, exp_lat);
  endtask

  task automatic ack_job(input int which);
    if (which == 0) ak2 = 1'b1; else ak8 = 1'b1;
    tick();
    ak2 = 1'b0; ak8 = 1'b0;
    chk("done cleared by ack", (which == 0) ? done2 : done8, 0);
  endtask

  typedef struct {
    logic        lv, sel, idx;
    logic [15:0] data;
    logic        st, ak;
    logic [4:0]  fl;   // {ready, busy, done, arrayClr, doProcess}
    logic [15:0] row, col;
  } vec_t;

  function automatic vec_t mk(logic lv, logic sel, logic idx, logic [15:0] data,
                              logic st, logic ak, logic [4:0] fl,
                              logic [15:0] row, logic [15:0] col);
    vec_t v;
    v.lv = lv; v.sel = sel; v.idx = idx; v.data = data;
    v.st = st; v.ak = ak; v.fl = fl; v.row = row; v.col = col;
    return v;
  endfunction

  vec_t        vt [12];
  logic [63:0] d8;
  logic        done_seen;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    // A=[[1,2],[3,4]] by rows, B=[[5,6],[7,8]] by columns, then one job.
    vt[0]  = mk(1, 0, 0, 16'h0201, 0, 0, 5'b10000, 16'h0000, 16'h0000);
    vt[1]  = mk(1, 0, 1, 16'h0403, 0, 0, 5'b10000, 16'h0000, 16'h0000);
    vt[2]  = mk(1, 1, 0, 16'h0705, 0, 0, 5'b10000, 16'h0000, 16'h0000);
    vt[3]  = mk(1, 1, 1, 16'h0806, 0, 0, 5'b10000, 16'h0000, 16'h0000);
    vt[4]  = mk(0, 0, 0, 16'h0000, 1, 0, 5'b01010, 16'h0000, 16'h0000);
    vt[5]  = mk(0, 0, 0, 16'h0000, 0, 0, 5'b01001, 16'h0001, 16'h0005);
    vt[6]  = mk(1, 0, 0, 16'h6363, 0, 0, 5'b01001, 16'h0302, 16'h0607);
    vt[7]  = mk(0, 0, 0, 16'h0000, 1, 0, 5'b01001, 16'h0400, 16'h0800);
    vt[8]  = mk(0, 0, 0, 16'h0000, 0, 0, 5'b01001, 16'h0000, 16'h0000);
    vt[9]  = mk(0, 0, 0, 16'h0000, 0, 0, 5'b00100, 16'h0000, 16'h0000);
    vt[10] = mk(0, 0, 0, 16'h0000, 0, 0, 5'b00100, 16'h0000, 16'h0000);
    vt[11] = mk(0, 0, 0, 16'h0000, 1, 1, 5'b10000, 16'h0000, 16'h0000);

    arst = 1'b1;
    ld2_v = 0; ld2_sel = 0; ld2_idx = 0; ld2_data = '0; st2 = 0; ak2 = 0;
    ld8_v = 0; ld8_sel = 0; ld8_idx = 0; ld8_data = '0; st8 = 0; ak8 = 0;
    tick();
    tick();
    chk("reset flags n2", {ready2, busy2, done2, clr2, dp2}, 5'b10000);
    chk("reset feeds n2", {row2, col2}, 0);
    chk("reset flags n8", {ready8, busy8, done8, clr8, dp8}, 5'b10000);
    chk("reset feeds n8", {row8, col8}, 0);
    arst = 1'b0;

    for (int v = 0; v < 12; v++) begin
      ld2_v = vt[v].lv; ld2_sel = vt[v].sel; ld2_idx = vt[v].idx;
      ld2_data = vt[v].data; st2 = vt[v].st; ak2 = vt[v].ak;
      tick();
      ld2_v = 0; st2 = 0; ak2 = 0;
      chk($sformatf("flags vec%0d", v), {ready2, busy2, done2, clr2, dp2}, vt[v].fl);
      chk($sformatf("rowFeed vec%0d", v), row2, vt[v].row);
      chk($sformatf("colFeed vec%0d", v), col2, vt[v].col);
    end
    chk("c00 job1", g_arr[0].c[0][0], 19);
    chk("c01 job1", g_arr[0].c[0][1], 22);
    chk("c10 job1", g_arr[0].c[1][0], 43);
    chk("c11 job1", g_arr[0].c[1][1], 50);

    // Load A row 1 = [9,9] in the same cycle as start.
    ld2_v = 1; ld2_sel = 0; ld2_idx = 1; ld2_data = 16'h0909; st2 = 1;
    wait_done(0, 6, "job2");
    chk("c00 job2", g_arr[0].c[0][0], 19);
    chk("c01 job2", g_arr[0].c[0][1], 22);
    chk("c10 job2", g_arr[0].c[1][0], 108);
    chk("c11 job2", g_arr[0].c[1][1], 126);
    ack_job(0);

    // Reset at FEED t=1 aborts the job and clears the buffers.
    st2 = 1;
    tick();
    st2 = 0;
    tick();
    tick();
    chk("rowFeed t1 before abort", row2, 16'h0902);
    arst = 1'b1;
    tick();
    arst = 1'b0;
    chk("flags after abort", {ready2, busy2, done2, clr2, dp2}, 5'b10000);
    chk("feeds after abort", {row2, col2}, 0);
    done_seen = 1'b0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (done2) done_seen = 1'b1;
    end
    chk("no done after abort", done_seen, 0);
    st2 = 1;
    wait_done(0, 6, "rerun");
    chk("c00 rerun", g_arr[0].c[0][0], 0);
    chk("c01 rerun", g_arr[0].c[0][1], 0);
    chk("c10 rerun", g_arr[0].c[1][0], 0);
    chk("c11 rerun", g_arr[0].c[1][1], 0);
    ack_job(0);

`ifdef SA_CTRL_PERF_CNT_EN
    st2 = 1;
    wait_done(0, 6, "perf job");
    ack_job(0);
    chk("jobCount", jobcnt2, 2);
    chk("busyCycles", busycyc2, 10);
`endif

    // N=8: A = identity, B[i][j] = i*8 + j - 32, so C must equal B.
    for (int i = 0; i < 8; i++) begin
      ld8_v = 1; ld8_sel = 0; ld8_idx = 3'(i);
      ld8_data = 64'd1 << (i*8);
      tick();
    end
    for (int j = 0; j < 8; j++) begin
      d8 = '0;
      for (int k = 0; k < 8; k++) d8[k*8 +: 8] = 8'(k*8 + j - 32);
      ld8_v = 1; ld8_sel = 1; ld8_idx = 3'(j); ld8_data = d8;
      tick();
    end
    ld8_v = 0;
    st8 = 1;
    wait_done(1, 24, "n8 job");
    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j < 8; j++) begin
        chk($sformatf("n8 c%0d%0d", i, j), g_arr[1].c[i][j], i*8 + j - 32);
      end
    end
    ack_job(1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
